sumador_serie: RTL and testbench

//  Bit-serial adder that accepts two WIDTH-bit operands and feeds them LSB-first,
//  one bit per clock, through one SumadorCompleto full-adder cell. A registered

---
 rtl/sumador_serie.sv | 174 +++++++++++++++++
 tb/tb_sumador_serie.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sumador_serie.sv
// rtl/sumador_serie.sv - bit-serial adder built around one full-adder cell
//
// sumador_completo : single-bit full adder (a + b + ci -> s, co).
// sumador_serie    : feeds two WIDTH-bit operands LSB-first through one
//                    sumador_completo, one bit per clock, with a registered carry.
//
// Optional feature macro: SUMADOR_SERIE_SUB_EN (adds the sub port, a - b mode).
//
// Ports (sumador_serie):
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands presented
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   sub        subtract request (SUMADOR_SERIE_SUB_EN only)
//   out_valid  result available (DONE only)
//   out_ready  consumer takes result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       final carry-out (in subtract mode, 1 = no borrow)

module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sumador_serie #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUMADOR_SERIE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               fa_s;
  logic               fa_co;

  sumador_completo u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready comes up on the first edge after reset release
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
`ifdef SUMADOR_SERIE_SUB_EN
          // a - b == a + ~b + 1 in two's complement
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        // result bits enter at the MSB so after WIDTH shifts bit 0 is in place
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cout_d  = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // no accept on the handoff edge: in_ready rises one cycle later
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_sumador_serie.sv
// tb/tb_sumador_serie.sv - directed self-checking bench for sumador_serie (WIDTH=8)

module tb_sumador_serie;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef SUMADOR_SERIE_SUB_EN
  logic       sub;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int errors;

  sumador_serie #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUMADOR_SERIE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec,
                        input bit hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = (i % 2 == 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_sum"}, 32'(sum), 32'(es));
        chk({tag, "_hold_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_sum_kept"}, 32'(sum), 32'(es));
  endtask

  logic [7:0] vec_a [3];
  logic [7:0] vec_b [3];
  logic       vec_c [3];
  logic [7:0] vec_s [3];
  logic       vec_o [3];

  initial begin
    int done_n;
    int acc_n;
    int last_acc;

    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SUMADOR_SERIE_SUB_EN
    sub = 1'b0;
`endif

    // reset values
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("backpressure", 8'h5A, 8'h0F, 1'b0, 8'h69, 1'b0, 1'b1);

    // back-to-back: in_valid and out_ready held high
    vec_a[0] = 8'h12; vec_b[0] = 8'h34; vec_c[0] = 1'b0; vec_s[0] = 8'h46; vec_o[0] = 1'b0;
    vec_a[1] = 8'h80; vec_b[1] = 8'h80; vec_c[1] = 1'b0; vec_s[1] = 8'h00; vec_o[1] = 1'b1;
    vec_a[2] = 8'h7F; vec_b[2] = 8'h01; vec_c[2] = 1'b1; vec_s[2] = 8'h81; vec_o[2] = 1'b0;
    done_n = 0; acc_n = 0; last_acc = 0;
    a = vec_a[0]; b = vec_b[0]; cin = vec_c[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 200 && done_n < 3; c++) begin
      if (out_valid) begin
        chk("b2b_sum", 32'(sum), 32'(vec_s[done_n]));
        chk("b2b_cout", 32'(cout), 32'(vec_o[done_n]));
        done_n++;
        if (done_n < 3) begin
          a = vec_a[done_n]; b = vec_b[done_n]; cin = vec_c[done_n];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_ready && in_valid && acc_n < 3) begin
        if (acc_n > 0) chk("b2b_gap", 32'(c - last_acc), 32'd10);
        last_acc = c;
        acc_n++;
      end
      @(negedge clk);
    end
    chk("b2b_done", 32'(done_n), 32'd3);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // reset in the middle of RUN, at counter == 3
    chk("midrst_pre_in_ready", 32'(in_ready), 32'd1);
    a = 8'hAB; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_post_in_ready", 32'(in_ready), 32'd1);
    run_op("after_rst_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

`ifdef SUMADOR_SERIE_SUB_EN
    sub = 1'b1;
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    sub = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
